// File: rtl/dram_resp_pkg.sv
// Shared definitions for the DRAM response block: FSM encoding, access
// direction constants and the address legality check.
package dram_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Misaligned, or pointing past the last word of the store.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dram_array.sv
// Single-port synchronous RAM, DEPTH x 32, with write enable and a registered
// read port. Storage is not reset so it can map onto block RAM.
module dram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Output register holds its value until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dram_resp.sv
// Memory-stage responder: accepts one request at a time, inserts WAIT wait
// states, then pulses ram_ready_o with an optional error qualifier.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no access in flight; ram_en_i is accepted here
// WAIT    | counting down wait states for a legal access
// DONE    | one-cycle completion, ram_ready_o high
module dram_resp
    import dram_resp_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ram_en_i,
    input  logic        ram_rw_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic        ram_ready_o,
    output logic        ram_err_o,
    output logic        busy_o
);

    localparam int         AW      = $clog2(DEPTH);
    localparam bit         NO_WAIT = (WAIT == 0);
    localparam logic [3:0] WAIT_LD = NO_WAIT ? 4'd0 : 4'(WAIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rw_q;
    logic        err_q;

    logic        accept;
    logic        in_err;
    logic        mem_en;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_rw;

    assign accept = (state_q == ST_IDLE) && ram_en_i;
    assign in_err = addr_err(ram_addr_i, AW);

    // With no wait states the RAM fires on the accept edge itself, so it must
    // see the live inputs rather than the not-yet-latched copies.
    assign acc_addr  = accept ? ram_addr_i : addr_q;
    assign acc_wdata = accept ? ram_data_i : wdata_q;
    assign acc_rw    = accept ? ram_rw_i   : rw_q;

    assign mem_en = (accept && !in_err && NO_WAIT) ||
                    ((state_q == ST_WAIT) && (cnt_q == 4'd0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ram_en_i) begin
                    if (in_err || NO_WAIT) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rw_q    <= RW_READ;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= ram_addr_i;
                wdata_q <= ram_data_i;
                rw_q    <= ram_rw_i;
                err_q   <= in_err;
            end
        end
    end

    dram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (mem_en),
        .we_i    (acc_rw == RW_WRITE),
        .addr_i  (acc_addr[AW+1:2]),
        .wdata_i (acc_wdata),
        .rdata_o (ram_data_o)
    );

    assign ram_ready_o = (state_q == ST_DONE);
    assign ram_err_o   = (state_q == ST_DONE) && err_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dram_resp.sv
// Bench for dram_resp: three instances (WAIT = 0, 1, 3) driven by random and
// directed accesses, checked against a word-array model of the store.
module tb_dram_resp;

    logic        clk;
    logic        rst_n;
    logic        en    [3];
    logic        rw    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        errs  [3];
    logic        busy  [3];

    int total = 0;
    int bad   = 0;

    int          waits [3] = '{0, 1, 3};
    logic [31:0] mm      [3][256];
    logic [31:0] last_rd [3];

    dram_resp #(.DEPTH(256), .WAIT(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .ram_en_i(en[0]), .ram_rw_i(rw[0]),
        .ram_addr_i(addr[0]), .ram_data_i(wdata[0]), .ram_data_o(rdata[0]),
        .ram_ready_o(ready[0]), .ram_err_o(errs[0]), .busy_o(busy[0]));

    dram_resp #(.DEPTH(256), .WAIT(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .ram_en_i(en[1]), .ram_rw_i(rw[1]),
        .ram_addr_i(addr[1]), .ram_data_i(wdata[1]), .ram_data_o(rdata[1]),
        .ram_ready_o(ready[1]), .ram_err_o(errs[1]), .busy_o(busy[1]));

    dram_resp #(.DEPTH(256), .WAIT(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .ram_en_i(en[2]), .ram_rw_i(rw[2]),
        .ram_addr_i(addr[2]), .ram_data_i(wdata[2]), .ram_data_o(rdata[2]),
        .ram_ready_o(ready[2]), .ram_err_o(errs[2]), .busy_o(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: predicts latency, error and read data from the access rules.
    task automatic model_xact(input int k, input logic rw_v, input logic [31:0] a,
                              input logic [31:0] d, output int lat, output logic [31:0] rd,
                              output logic e);
        e   = ((a % 4) != 0) || (a >= 32'h400);
        lat = e ? 1 : waits[k] + 1;
        if (!e && rw_v)  mm[k][a / 4] = d;
        if (!e && !rw_v) last_rd[k] = mm[k][a / 4];
        rd = last_rd[k];
    endtask

    // One access; inputs are scrambled right after the accept edge.
    task automatic xact(input int k, input logic rw_v, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic e, output bit busy_ok);
        @(negedge clk);
        en[k] = 1'b1; rw[k] = rw_v; addr[k] = a; wdata[k] = d;
        @(posedge clk);
        #1;
        en[k] = 1'b0; rw[k] = 1'($urandom); addr[k] = $urandom; wdata[k] = $urandom;
        lat = 99; busy_ok = 1'b1; rd = 'x; e = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy[k] !== 1'b1) busy_ok = 1'b0;
            if (ready[k] === 1'b1) begin
                lat = c; rd = rdata[k]; e = errs[k];
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; rw[k] = 1'b0; addr[k] = '0; wdata[k] = '0; last_rd[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rdata[k] !== 32'd0) begin bad++; $display("FAIL reset_data[%0d] got=%h exp=0", k, rdata[k]); end
            total++;
            if (ready[k] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got=%b exp=0", k, ready[k]); end
            total++;
            if (errs[k] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] got=%b exp=0", k, errs[k]); end
            total++;
            if (busy[k] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b exp=0", k, busy[k]); end
        end
        rst_n = 1'b1;
    endtask

    // Directed list of (rw, addr, data) on a given instance.
    task automatic run_list(input int k, input string tag, input logic rws [$],
                            input logic [31:0] as [$], input logic [31:0] ds [$]);
        int lat, elat; logic [31:0] rd, erd; logic e, ee; bit bok;
        foreach (as[i]) begin
            model_xact(k, rws[i], as[i], ds[i], elat, erd, ee);
            xact(k, rws[i], as[i], ds[i], lat, rd, e, bok);
            total++;
            if (lat !== elat) begin bad++; $display("FAIL %s_lat[%0d] a=%h got=%0d exp=%0d", tag, i, as[i], lat, elat); end
            total++;
            if (e !== ee) begin bad++; $display("FAIL %s_err[%0d] a=%h got=%b exp=%b", tag, i, as[i], e, ee); end
            total++;
            if (rd !== erd) begin bad++; $display("FAIL %s_data[%0d] a=%h got=%h exp=%h", tag, i, as[i], rd, erd); end
            total++;
            if (!bok) begin bad++; $display("FAIL %s_busy[%0d] got=low exp=high", tag, i); end
        end
    endtask

    task automatic test_write_read();
        run_list(1, "wr_rd",
                 '{1'b1, 1'b1, 1'b0, 1'b0},
                 '{32'h0, 32'h10, 32'h10, 32'h0},
                 '{$urandom, 32'hDEADBEEF, $urandom, $urandom});
    endtask

    task automatic test_errors();
        run_list(1, "err",
                 '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
                 '{32'h10, 32'h13, 32'h10, 32'h400, 32'h0, 32'h3FC, 32'h3FC, 32'h8000_0010, 32'h10},
                 '{$urandom, $urandom, $urandom, 32'hBAD0BAD0, $urandom, 32'hCAFE_F00D, $urandom, $urandom, $urandom});
    endtask

    task automatic test_back_to_back();
        int lat, idx; logic [31:0] rd, ed [3]; logic e, exp_rdy; bit bok;
        logic [31:0] ras [3] = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 3; i++) begin
            logic [31:0] d = $urandom;
            model_xact(0, 1'b1, ras[i], d, lat, rd, e);
            xact(0, 1'b1, ras[i], d, lat, rd, e, bok);
        end
        for (int i = 0; i < 3; i++) model_xact(0, 1'b0, ras[i], 32'd0, lat, ed[i], e);
        @(negedge clk);
        en[0] = 1'b1; rw[0] = 1'b0; addr[0] = ras[0];
        @(posedge clk);
        idx = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            exp_rdy = (c % 2 == 1) && (c <= 5);
            total++;
            if (ready[0] !== exp_rdy) begin bad++; $display("FAIL b2b_ready[c%0d] got=%b exp=%b", c, ready[0], exp_rdy); end
            total++;
            if (busy[0] !== exp_rdy) begin bad++; $display("FAIL b2b_busy[c%0d] got=%b exp=%b", c, busy[0], exp_rdy); end
            if (exp_rdy && idx < 3) begin
                total++;
                if (rdata[0] !== ed[idx]) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", idx, rdata[0], ed[idx]); end
                idx++;
            end
            if (c == 2) addr[0] = ras[1];
            if (c == 4) addr[0] = ras[2];
            if (c == 5) en[0] = 1'b0;
        end
    endtask

    task automatic test_random_wait();
        int lat, elat; logic [31:0] a, d, rd, erd; logic r, e, ee; bit bok;
        for (int i = 0; i < 8; i++) begin
            a = 32'h20 + 32'(i * 4); d = $urandom;
            model_xact(2, 1'b1, a, d, elat, erd, ee);
            xact(2, 1'b1, a, d, lat, rd, e, bok);
        end
        for (int i = 0; i < 40; i++) begin
            r = 1'($urandom);
            a = 32'h20 + 32'($urandom_range(0, 7) * 4);
            case ($urandom_range(0, 5))
                0: a = a | 32'($urandom_range(1, 3));
                1: a = a | 32'h0001_0000;
                default: ;
            endcase
            d = $urandom;
            model_xact(2, ~r, a, d, elat, erd, ee);
            xact(2, ~r, a, d, lat, rd, e, bok);
            total++;
            if (lat !== elat) begin bad++; $display("FAIL rnd_lat[%0d] a=%h got=%0d exp=%0d", i, a, lat, elat); end
            total++;
            if (e !== ee) begin bad++; $display("FAIL rnd_err[%0d] a=%h got=%b exp=%b", i, a, e, ee); end
            total++;
            if (rd !== erd) begin bad++; $display("FAIL rnd_data[%0d] a=%h got=%h exp=%h", i, a, rd, erd); end
            total++;
            if (!bok) begin bad++; $display("FAIL rnd_busy[%0d] got=low exp=high", i); end
        end
    endtask

    task automatic test_reset_mid();
        int lat, elat; logic [31:0] rd, erd; logic e, ee; bit bok;
        @(negedge clk);
        en[2] = 1'b1; rw[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h1234;
        @(posedge clk);
        #1 en[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) last_rd[k] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({ready[2], errs[2], busy[2]} !== 3'b000 || rdata[2] !== 32'd0) begin
                bad++; $display("FAIL rstmid_out[c%0d] got=rdy%b err%b busy%b data%h exp=0", c, ready[2], errs[2], busy[2], rdata[2]);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (ready[2] !== 1'b0) begin bad++; $display("FAIL rstmid_ready[c%0d] got=%b exp=0", c, ready[2]); end
        end
        model_xact(2, 1'b0, 32'h20, 32'd0, elat, erd, ee);
        xact(2, 1'b0, 32'h20, 32'd0, lat, rd, e, bok);
        total++;
        if (rd !== erd) begin bad++; $display("FAIL rstmid_keep got=%h exp=%h", rd, erd); end
        total++;
        if (lat !== elat) begin bad++; $display("FAIL rstmid_lat got=%0d exp=%0d", lat, elat); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_back_to_back();
        test_random_wait();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
